// File: rtl/vdp_cpu_port.sv
// CPU-side port of a TMS9918-style VDP: control latch, registers, VRAM address counter,
// read-ahead buffer, status/interrupt and a request/ack VRAM sequencer. Optional: VDP_ACK_TIMEOUT_EN.
module vdp_cpu_port #(
   parameter int ADDR_W         = 14,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              io_wr,
   input  logic              io_rd,
   input  logic              port_sel,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              vram_req,
   output logic              vram_we,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_wdata,
   input  logic [7:0]        vram_rdata,
   input  logic              vram_ack,
   output logic [63:0]       regs,
   input  logic              ev_frame,
   input  logic              ev_coll,
   input  logic              ev_5th,
   input  logic [4:0]        ev_5th_num,
   output logic              int_n,
   output logic              busy,
   output logic              overrun
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t            state_q, state_d;
   logic [63:0]       regs_q, regs_d;
   logic [ADDR_W-1:0] acnt_q, acnt_d, req_addr_q, req_addr_d, defer_addr_q, defer_addr_d;
   logic [7:0]        rbuf_q, rbuf_d, latch_q, latch_d, req_wdata_q, req_wdata_d;
   logic [7:0]        pend_wdata_q, pend_wdata_d;
   logic              flag_q, flag_d, clr_q, clr_d, int_n_q, int_n_d, ovr_q, ovr_d;
   logic              st_f_q, st_f_d, st_c_q, st_c_d, st_5s_q, st_5s_d;
   logic [4:0]        st_num_q, st_num_d;
   logic              req_we_q, req_we_d, pend_vld_q, pend_vld_d, pend_we_q, pend_we_d;
   logic              defer_vld_q, defer_vld_d;

   logic              acc_vld, acc_we, set_addr, issue, iss_we, tmo_hit;
   logic [7:0]        acc_wdata, iss_wdata;
   logic [ADDR_W-1:0] set_val;

`ifdef VDP_ACK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;

   assign tmo_hit = (state_q == REQ) && !vram_ack && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_d = '0;
      if (state_q == REQ && !issue) tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tmo_q <= '0;
      else          tmo_q <= tmo_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;      regs_d       = regs_q;
      acnt_d       = acnt_q;       rbuf_d       = rbuf_q;
      latch_d      = latch_q;      flag_d       = flag_q;
      st_f_d       = st_f_q;       st_c_d       = st_c_q;
      st_5s_d      = st_5s_q;      st_num_d     = st_num_q;
      ovr_d        = ovr_q;        req_we_d     = req_we_q;
      req_addr_d   = req_addr_q;   req_wdata_d  = req_wdata_q;
      pend_vld_d   = pend_vld_q;   pend_we_d    = pend_we_q;
      pend_wdata_d = pend_wdata_q; defer_vld_d  = defer_vld_q;
      defer_addr_d = defer_addr_q;
      clr_d        = io_rd & port_sel;
      int_n_d      = ~(st_f_q & regs_q[13]);
      acc_vld = 1'b0; acc_we = 1'b0; acc_wdata = 8'h00;
      set_addr = 1'b0; set_val = ADDR_W'({cpu_din[5:0], latch_q});
      issue = 1'b0; iss_we = 1'b0; iss_wdata = 8'h00;

      // Status clear lands first so a same-cycle event re-sets the bit.
      if (clr_q) begin
         st_f_d = 1'b0; st_c_d = 1'b0; st_5s_d = 1'b0; flag_d = 1'b0;
      end
      if (ev_frame) st_f_d = 1'b1;
      if (ev_coll)  st_c_d = 1'b1;
      if (ev_5th && !st_5s_q) begin
         st_5s_d  = 1'b1;
         st_num_d = ev_5th_num;
      end

      if (io_wr && port_sel) begin
         if (!flag_q) begin
            latch_d = cpu_din;
            flag_d  = 1'b1;
         end else begin
            flag_d = 1'b0;
            if (cpu_din[7]) begin
               if (cpu_din[5:3] == 3'd0) regs_d[{cpu_din[2:0], 3'b000} +: 8] = latch_q;
            end else begin
               set_addr = 1'b1;
               acc_vld  = !cpu_din[6];
            end
         end
      end
      if (io_wr && !port_sel) begin
         rbuf_d = cpu_din; flag_d = 1'b0;
         acc_vld = 1'b1; acc_we = 1'b1; acc_wdata = cpu_din;
      end
      if (io_rd && !port_sel) begin
         flag_d = 1'b0; acc_vld = 1'b1;
      end

      // An address set during a transaction is held until the in-flight ack.
      if (set_addr) begin
         if (state_q == IDLE) acnt_d = set_val;
         else begin
            defer_vld_d  = 1'b1;
            defer_addr_d = set_val;
         end
      end

      case (state_q)
         IDLE: begin
            if (pend_vld_q) begin
               issue = 1'b1; iss_we = pend_we_q; iss_wdata = pend_wdata_q;
               pend_vld_d = acc_vld; pend_we_d = acc_we; pend_wdata_d = acc_wdata;
            end else if (acc_vld) begin
               issue = 1'b1; iss_we = acc_we; iss_wdata = acc_wdata;
            end
         end
         REQ: begin
            if (acc_vld) begin
               if (pend_vld_q) ovr_d = 1'b1;
               else begin
                  pend_vld_d = 1'b1; pend_we_d = acc_we; pend_wdata_d = acc_wdata;
               end
            end
            if (vram_ack || tmo_hit) begin
               if (!req_we_q) rbuf_d = vram_ack ? vram_rdata : 8'hFF;
               if (tmo_hit) ovr_d = 1'b1;
               acnt_d      = defer_vld_d ? defer_addr_d : req_addr_q + ADDR_W'(1);
               defer_vld_d = 1'b0;
               if (pend_vld_q) begin
                  issue = 1'b1; iss_we = pend_we_q; iss_wdata = pend_wdata_q;
                  pend_vld_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         state_d     = REQ;
         req_we_d    = iss_we;
         req_wdata_d = iss_wdata;
         req_addr_d  = acnt_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;    regs_q <= '0;       acnt_q <= '0;      rbuf_q <= '0;
         latch_q <= '0;      flag_q <= 1'b0;     clr_q <= 1'b0;     int_n_q <= 1'b1;
         ovr_q <= 1'b0;      st_f_q <= 1'b0;     st_c_q <= 1'b0;    st_5s_q <= 1'b0;
         st_num_q <= '0;     req_we_q <= 1'b0;   req_addr_q <= '0;  req_wdata_q <= '0;
         pend_vld_q <= 1'b0; pend_we_q <= 1'b0;  pend_wdata_q <= '0;
         defer_vld_q <= 1'b0; defer_addr_q <= '0;
      end else begin
         state_q <= state_d;       regs_q <= regs_d;         acnt_q <= acnt_d;
         rbuf_q <= rbuf_d;         latch_q <= latch_d;       flag_q <= flag_d;
         clr_q <= clr_d;           int_n_q <= int_n_d;       ovr_q <= ovr_d;
         st_f_q <= st_f_d;         st_c_q <= st_c_d;         st_5s_q <= st_5s_d;
         st_num_q <= st_num_d;     req_we_q <= req_we_d;     req_addr_q <= req_addr_d;
         req_wdata_q <= req_wdata_d; pend_vld_q <= pend_vld_d; pend_we_q <= pend_we_d;
         pend_wdata_q <= pend_wdata_d; defer_vld_q <= defer_vld_d; defer_addr_q <= defer_addr_d;
      end
   end

   assign cpu_dout   = port_sel ? {st_f_q, st_5s_q, st_c_q, (st_5s_q ? st_num_q : 5'h1F)} : rbuf_q;
   assign vram_req   = (state_q == REQ);
   assign vram_we    = req_we_q;
   assign vram_addr  = req_addr_q;
   assign vram_wdata = req_wdata_q;
   assign regs       = regs_q;
   assign int_n      = int_n_q;
   assign busy       = (state_q != IDLE) | pend_vld_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: register/status vector table, hand-timed VRAM sequences,
// then random CPU traffic against a byte-level VDP model with a random-latency arbiter.
module tb_vdp_cpu_port;

   logic        clk = 1'b0;
   logic        reset_n, io_wr, io_rd, port_sel;
   logic [7:0]  cpu_din, cpu_dout, vram_wdata, vram_rdata;
   logic        vram_req, vram_we, vram_ack;
   logic [13:0] vram_addr;
   logic [63:0] regs;
   logic        ev_frame, ev_coll, ev_5th, int_n, busy, overrun;
   logic [4:0]  ev_5th_num;

   logic        auto_en, auto_ack, man_ack;
   logic [7:0]  auto_rdata, man_rdata;
   logic [7:0]  mem_dut [16384];
   logic [7:0]  mem_ref [16384];

   int n_cmp = 0;
   int n_fail = 0;

   assign vram_ack   = auto_en ? auto_ack : man_ack;
   assign vram_rdata = auto_en ? auto_rdata : man_rdata;

   vdp_cpu_port #(.ADDR_W(14), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_rd(io_rd), .port_sel(port_sel),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_req(vram_req), .vram_we(vram_we),
      .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
      .vram_ack(vram_ack), .regs(regs), .ev_frame(ev_frame), .ev_coll(ev_coll),
      .ev_5th(ev_5th), .ev_5th_num(ev_5th_num), .int_n(int_n), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cpu_wr(input logic port, input logic [7:0] d);
      io_wr = 1'b1; port_sel = port; cpu_din = d;
      tick();
      io_wr = 1'b0;
   endtask

   task automatic cpu_rd(input logic port, output logic [7:0] d);
      io_rd = 1'b1; port_sel = port;
      #1;
      d = cpu_dout;
      tick();
      io_rd = 1'b0;
   endtask

   task automatic man_ack_cycle(input logic [7:0] rd);
      man_rdata = rd; man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && busy; i++) tick();
      chk("wait_idle_busy", {63'd0, busy}, 64'd0);
   endtask

   // Arbiter stand-in: acks each request after 0..3 cycles and services it from mem_dut.
   initial begin : responder
      int   dly;
      logic was;
      auto_ack = 1'b0; auto_rdata = 8'h00; dly = -1;
      forever begin
         @(posedge clk);
         #1;
         was = auto_ack;
         auto_ack = 1'b0;
         if (was || !vram_req || !auto_en) dly = -1;
         if (auto_en && vram_req) begin
            if (dly < 0) dly = int'($urandom_range(0, 3));
            if (dly == 0) begin
               auto_ack   = 1'b1;
               auto_rdata = mem_dut[vram_addr];
               if (vram_we) mem_dut[vram_addr] = vram_wdata;
            end else begin
               dly--;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        rd;
      logic [7:0]  din;
      logic [7:0]  exp_dout;
      logic [63:0] exp_regs;
   } vec_t;

   initial begin : main
      vec_t        tbl [17];
      logic [7:0]  d;
      logic [63:0] ref_regs;
      logic [13:0] ref_a;
      logic [7:0]  ref_buf, ref_latch, v;
      logic        ref_flag;
      int          op, nbad;

      tbl[0]  = '{1'b1, 8'h00, 8'h1F, 64'h0};
      tbl[1]  = '{1'b0, 8'h34, 8'h00, 64'h0};
      tbl[2]  = '{1'b0, 8'h87, 8'h00, 64'h3400_0000_0000_0000};
      tbl[3]  = '{1'b0, 8'h12, 8'h00, 64'h3400_0000_0000_0000};
      tbl[4]  = '{1'b0, 8'hC9, 8'h00, 64'h3400_0000_0000_0000};
      tbl[5]  = '{1'b0, 8'h20, 8'h00, 64'h3400_0000_0000_0000};
      tbl[6]  = '{1'b0, 8'h81, 8'h00, 64'h3400_0000_0000_2000};
      tbl[7]  = '{1'b0, 8'h55, 8'h00, 64'h3400_0000_0000_2000};
      tbl[8]  = '{1'b0, 8'h80, 8'h00, 64'h3400_0000_0000_2055};
      tbl[9]  = '{1'b0, 8'h66, 8'h00, 64'h3400_0000_0000_2055};
      tbl[10] = '{1'b1, 8'h00, 8'h1F, 64'h3400_0000_0000_2055};
      tbl[11] = '{1'b0, 8'h77, 8'h00, 64'h3400_0000_0000_2055};
      tbl[12] = '{1'b0, 8'h82, 8'h00, 64'h3400_0000_0077_2055};
      tbl[13] = '{1'b0, 8'hAB, 8'h00, 64'h3400_0000_0077_2055};
      tbl[14] = '{1'b0, 8'h8F, 8'h00, 64'h3400_0000_0077_2055};
      tbl[15] = '{1'b0, 8'h01, 8'h00, 64'h3400_0000_0077_2055};
      tbl[16] = '{1'b0, 8'h83, 8'h00, 64'h3400_0000_0177_2055};

      reset_n = 1'b0; io_wr = 1'b0; io_rd = 1'b0; port_sel = 1'b0; cpu_din = 8'h00;
      ev_frame = 1'b0; ev_coll = 1'b0; ev_5th = 1'b0; ev_5th_num = 5'd0;
      auto_en = 1'b0; man_ack = 1'b0; man_rdata = 8'h00;
      repeat (3) tick();
      chk("rst_regs", regs, 64'd0);
      chk("rst_req", {63'd0, vram_req}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_overrun", {63'd0, overrun}, 64'd0);
      chk("rst_int_n", {63'd0, int_n}, 64'd1);
      reset_n = 1'b1;
      tick();

      // Control-port register writes and status reads, including flag reset by status read.
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].rd) begin
            cpu_rd(1'b1, d);
            chk("tbl_status", {56'd0, d}, {56'd0, tbl[i].exp_dout});
         end else begin
            cpu_wr(1'b1, tbl[i].din);
         end
         chk("tbl_regs", regs, tbl[i].exp_regs);
         tick();
      end

      // Data write with ack withheld for three request cycles.
      cpu_wr(1'b1, 8'h00);
      cpu_wr(1'b1, 8'h40);
      cpu_wr(1'b0, 8'hAA);
      chk("wr_req", {63'd0, vram_req}, 64'd1);
      chk("wr_fields", {vram_we, vram_addr, vram_wdata}, {1'b1, 14'h0000, 8'hAA});
      tick();
      chk("wr_hold2", {vram_req, vram_we, vram_addr, vram_wdata}, {1'b1, 1'b1, 14'h0000, 8'hAA});
      tick();
      chk("wr_hold3", {vram_req, vram_we, vram_addr, vram_wdata}, {1'b1, 1'b1, 14'h0000, 8'hAA});
      man_ack_cycle(8'h00);
      chk("wr_done", {62'd0, vram_req, busy}, 64'd0);
      cpu_wr(1'b0, 8'hBB);
      chk("wr_next_addr", {vram_req, vram_we, vram_addr, vram_wdata}, {1'b1, 1'b1, 14'h0001, 8'hBB});
      man_ack_cycle(8'h00);

      // Read setup at the top of VRAM, counter wraps, read-ahead buffer delivers.
      cpu_wr(1'b1, 8'hFF);
      cpu_wr(1'b1, 8'h3F);
      chk("pf_req", {vram_req, vram_we, vram_addr}, {1'b1, 1'b0, 14'h3FFF});
      man_ack_cycle(8'h5C);
      cpu_rd(1'b0, d);
      chk("pf_data", {56'd0, d}, 64'h5C);
      chk("pf_wrap_req", {vram_req, vram_we, vram_addr}, {1'b1, 1'b0, 14'h0000});
      man_ack_cycle(8'h00);

      // Three back-to-back writes: one in flight, one pending, one dropped.
      cpu_wr(1'b1, 8'h10);
      cpu_wr(1'b1, 8'h41);
      chk("ovr_before", {63'd0, overrun}, 64'd0);
      io_wr = 1'b1; port_sel = 1'b0;
      cpu_din = 8'h01; tick();
      cpu_din = 8'h02; tick();
      cpu_din = 8'h03; tick();
      io_wr = 1'b0;
      chk("ovr_set", {63'd0, overrun}, 64'd1);
      chk("ovr_first", {vram_req, vram_addr, vram_wdata}, {1'b1, 14'h0110, 8'h01});
      man_ack_cycle(8'h00);
      chk("ovr_second", {vram_req, vram_addr, vram_wdata}, {1'b1, 14'h0111, 8'h02});
      man_ack_cycle(8'h00);
      tick(); tick();
      chk("ovr_no_third", {62'd0, vram_req, busy}, 64'd0);

      // Frame interrupt with R1 bit5 set, status clear and set-beats-clear.
      chk("int_idle", {63'd0, int_n}, 64'd1);
      ev_frame = 1'b1; tick(); ev_frame = 1'b0; tick();
      chk("int_fall", {63'd0, int_n}, 64'd0);
      cpu_rd(1'b1, d);
      chk("int_status", {56'd0, d}, 64'h9F);
      tick(); tick();
      chk("int_rise", {63'd0, int_n}, 64'd1);
      ev_frame = 1'b1; tick(); ev_frame = 1'b0; tick();
      cpu_rd(1'b1, d);
      ev_frame = 1'b1; tick(); ev_frame = 1'b0; tick();
      cpu_rd(1'b1, d);
      chk("f_set_wins", {56'd0, d}, 64'h9F);
      tick(); tick();
      ev_coll = 1'b1; ev_5th = 1'b1; ev_5th_num = 5'h0A; tick();
      ev_coll = 1'b0; ev_5th_num = 5'h03; tick();
      ev_5th = 1'b0;
      cpu_rd(1'b1, d);
      chk("status_5s_c", {56'd0, d}, 64'h6A);
      tick(); tick();

      // Reset while a prefetch is in flight; the late ack must be ignored.
      cpu_wr(1'b1, 8'h00);
      cpu_wr(1'b1, 8'h02);
      chk("rst_inflight", {vram_req, vram_addr}, {1'b1, 14'h0200});
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_async", {vram_req, busy, overrun, int_n}, {1'b0, 1'b0, 1'b0, 1'b1});
      chk("rst_async_regs", regs, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      man_ack_cycle(8'h77);
      cpu_rd(1'b0, d);
      chk("rst_late_ack_buf", {56'd0, d}, 64'h00);
      chk("rst_late_ack_addr", {vram_req, vram_addr}, {1'b1, 14'h0000});
      man_ack_cycle(8'h00);
      tick();

      // Random traffic against a byte-level VDP model.
      for (int i = 0; i < 16384; i++) begin
         v = 8'($urandom);
         mem_dut[i] = v;
         mem_ref[i] = v;
      end
      reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
      auto_en = 1'b1;
      ref_regs = 64'd0; ref_a = 14'd0; ref_buf = 8'd0; ref_latch = 8'd0; ref_flag = 1'b0;
      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 9));
         v  = 8'($urandom);
         if (op <= 2) begin
            cpu_wr(1'b0, v);
            mem_ref[ref_a] = v; ref_buf = v; ref_a = ref_a + 14'd1; ref_flag = 1'b0;
         end else if (op <= 5) begin
            cpu_rd(1'b0, d);
            chk("rnd_data_rd", {56'd0, d}, {56'd0, ref_buf});
            ref_buf = mem_ref[ref_a]; ref_a = ref_a + 14'd1; ref_flag = 1'b0;
         end else if (op <= 8) begin
            cpu_wr(1'b1, v);
            if (!ref_flag) begin
               ref_latch = v; ref_flag = 1'b1;
            end else begin
               ref_flag = 1'b0;
               if (v[7]) begin
                  if (v[5:3] == 3'd0) ref_regs[v[2:0]*8 +: 8] = ref_latch;
               end else begin
                  ref_a = {v[5:0], ref_latch};
                  if (!v[6]) begin
                     ref_buf = mem_ref[ref_a]; ref_a = ref_a + 14'd1;
                  end
               end
            end
            chk("rnd_regs", regs, ref_regs);
         end else begin
            cpu_rd(1'b1, d);
            chk("rnd_status", {56'd0, d}, 64'h1F);
            ref_flag = 1'b0;
         end
         tick();
         wait_idle();
      end
      nbad = 0;
      for (int i = 0; i < 16384; i++) if (mem_dut[i] !== mem_ref[i]) nbad++;
      chk("rnd_vram_image", 64'(nbad), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
